// File: rtl/stream_reader_if.sv
// stream_reader_if: job, read-request, completion, notify and data stream signals of stream_reader
interface stream_reader_if;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [47:0]  cfg_vaddr;
    logic [31:0]  cfg_len;
    logic         sq_rd_valid;
    logic         sq_rd_ready;
    logic [47:0]  sq_rd_vaddr;
    logic [27:0]  sq_rd_len;
    logic [3:0]   sq_rd_strm;
    logic         sq_rd_last;
    logic         cq_rd_valid;
    logic         cq_rd_ready;
    logic         notify_valid;
    logic         notify_ready;
    logic [31:0]  notify_value;
    logic         in_tvalid;
    logic         in_tready;
    logic [511:0] in_tdata;
    logic [63:0]  in_tkeep;
    logic         out_tvalid;
    logic         out_tready;
    logic [511:0] out_tdata;
    logic [63:0]  out_tkeep;
    logic         out_tlast;
    logic         busy;

    modport slave (
        input  cfg_valid, cfg_vaddr, cfg_len, sq_rd_ready, cq_rd_valid, notify_ready,
               in_tvalid, in_tdata, in_tkeep, out_tready,
        output cfg_ready, sq_rd_valid, sq_rd_vaddr, sq_rd_len, sq_rd_strm, sq_rd_last,
               cq_rd_ready, notify_valid, notify_value, in_tready,
               out_tvalid, out_tdata, out_tkeep, out_tlast, busy
    );

    modport master (
        output cfg_valid, cfg_vaddr, cfg_len, sq_rd_ready, cq_rd_valid, notify_ready,
               in_tvalid, in_tdata, in_tkeep, out_tready,
        input  cfg_ready, sq_rd_valid, sq_rd_vaddr, sq_rd_len, sq_rd_strm, sq_rd_last,
               cq_rd_ready, notify_valid, notify_value, in_tready,
               out_tvalid, out_tdata, out_tkeep, out_tlast, busy
    );
endinterface

// File: rtl/stream_reader.sv
// stream_reader: splits a job into host read requests and forwards the returned beats with keep/last
module stream_reader #(
    parameter int AXI_STRM_ID           = 0,
    parameter int TRANSFER_LENGTH_BYTES = 4096,
    parameter int MAX_OUTSTANDING       = 4
) (
    input logic            clk,
    input logic            rst,
    stream_reader_if.slave bus
);
    localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]     XFER    = 32'(TRANSFER_LENGTH_BYTES);
    localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [1:0]      IDLE    = 2'd0;
    localparam logic [1:0]      RUN     = 2'd1;
    localparam logic [1:0]      NOTIFY  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [47:0]   base_q;
    logic [31:0]   len_q, issued_q;
    logic [26:0]   beats_exp_q, in_beats_q, beats_exp_cfg;
    logic [32:0]   len_round;
    logic [OW-1:0] outst_q, outst_d;
    logic          done_q;
    logic          sq_valid_q, sq_last_q;
    logic [47:0]   sq_vaddr_q;
    logic [27:0]   sq_len_q, req_len;
    logic [31:0]   remaining;
    logic [511:0]  buf_data_q [2];
    logic [63:0]   buf_keep_q [2];
    logic          buf_last_q [2];
    logic          wr_q, rd_q;
    logic [1:0]    cnt_q;
    logic          cfg_hs, sq_hs, cq_hs, in_hs, out_hs, last_out, load, in_last;
    logic [63:0]   tail_keep, in_keep;

    assign cfg_hs    = bus.cfg_valid && state_q == IDLE;
    assign sq_hs     = sq_valid_q && bus.sq_rd_ready;
    assign cq_hs     = bus.cq_rd_valid && outst_q != '0;
    assign in_hs     = bus.in_tvalid && bus.in_tready;
    assign out_hs    = bus.out_tvalid && bus.out_tready;
    assign last_out  = out_hs && bus.out_tlast;
    assign remaining = len_q - issued_q;
    assign req_len   = remaining < XFER ? remaining[27:0] : XFER[27:0];
    assign outst_d   = (sq_hs && !cq_hs) ? outst_q + OW'(1) :
                       (cq_hs && !sq_hs) ? outst_q - OW'(1) : outst_q;
    // a new request is registered whenever the slot is free or being consumed and the window allows it
    assign load      = state_q == RUN && remaining != '0 && (!sq_valid_q || sq_hs) && outst_d < MAX_OUT;
    assign len_round = {1'b0, bus.cfg_len} + 33'd63;
    assign beats_exp_cfg = len_round[32:6];
    assign in_last   = in_beats_q == beats_exp_q - 27'd1;
    assign tail_keep = len_q[5:0] == 6'd0 ? {64{1'b1}} : ~({64{1'b1}} << len_q[5:0]);
    assign in_keep   = in_last ? tail_keep : {64{1'b1}};
    assign state_d   = (state_q == IDLE)   ? (bus.cfg_valid ? (bus.cfg_len != '0 ? RUN : NOTIFY) : IDLE) :
                       (state_q == RUN)    ? (((done_q || last_out) && outst_d == '0) ? NOTIFY : RUN) :
                       (state_q == NOTIFY) ? (bus.notify_ready ? IDLE : NOTIFY) : IDLE;

    assign bus.cfg_ready    = state_q == IDLE;
    assign bus.busy         = state_q != IDLE;
    assign bus.cq_rd_ready  = 1'b1;
    assign bus.sq_rd_valid  = sq_valid_q;
    assign bus.sq_rd_vaddr  = sq_vaddr_q;
    assign bus.sq_rd_len    = sq_len_q;
    assign bus.sq_rd_last   = sq_last_q;
    assign bus.sq_rd_strm   = 4'(AXI_STRM_ID);
    assign bus.notify_valid = state_q == NOTIFY;
    assign bus.notify_value = len_q;
    assign bus.in_tready    = state_q == RUN && in_beats_q != beats_exp_q && cnt_q != 2'd2;
    assign bus.out_tvalid   = cnt_q != 2'd0;
    assign bus.out_tdata    = buf_data_q[rd_q];
    assign bus.out_tkeep    = buf_keep_q[rd_q];
    assign bus.out_tlast    = buf_last_q[rd_q];

    // job control: FSM, request generation, outstanding window and beat accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            beats_exp_q <= '0;
            in_beats_q  <= '0;
            outst_q     <= '0;
            done_q      <= 1'b0;
            sq_valid_q  <= 1'b0;
            sq_vaddr_q  <= '0;
            sq_len_q    <= '0;
            sq_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            sq_valid_q <= load || (sq_valid_q && !sq_hs && state_q == RUN);
            if (cfg_hs) begin
                base_q      <= bus.cfg_vaddr;
                len_q       <= bus.cfg_len;
                issued_q    <= '0;
                in_beats_q  <= '0;
                beats_exp_q <= beats_exp_cfg;
                done_q      <= 1'b0;
            end else begin
                if (load) issued_q <= issued_q + {4'd0, req_len};
                if (in_hs) in_beats_q <= in_beats_q + 27'd1;
                if (last_out) done_q <= 1'b1;
            end
            if (load) begin
                sq_vaddr_q <= base_q + {16'd0, issued_q};
                sq_len_q   <= req_len;
                sq_last_q  <= remaining <= XFER;
            end
        end
    end

    // two-entry skid buffer between host data and user stream; keep/last are fixed up on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data_q <= '{default: '0};
            buf_keep_q <= '{default: '0};
            buf_last_q <= '{default: 1'b0};
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            if (in_hs) begin
                buf_data_q[wr_q] <= bus.in_tdata;
                buf_keep_q[wr_q] <= in_keep;
                buf_last_q[wr_q] <= in_last;
                wr_q             <= !wr_q;
            end
            if (out_hs) rd_q <= !rd_q;
            cnt_q <= cnt_q + {1'b0, in_hs} - {1'b0, out_hs};
        end
    end
endmodule

// File: tb/tb_stream_reader.sv
// tb_stream_reader: directed scenarios for stream_reader with a cycle-stepped host/user model
module tb_stream_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_reader_if bus ();

    stream_reader #(
        .AXI_STRM_ID(5),
        .TRANSFER_LENGTH_BYTES(4096),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int sq_cnt, pending, src_idx, out_idx, exp_beats, job_len;
    int out_pct = 100, sq_pct = 100;
    bit cq_en = 1, cq_force = 0, cfg_go = 0;
    int cfg_cyc, ntf_cyc, first_out_cyc, last_out_cyc, cq_first_cyc, both_cnt;
    bit ntf_seen;
    logic [31:0] ntf_val;
    logic [63:0] last_keep;
    logic [47:0] sq_addr [$];
    int          sq_lenq [$];
    bit          sq_lastq [$];
    bit          prev_hold, both_prev;
    logic [47:0] prev_addr;
    logic [27:0] prev_len;
    logic        prev_last;

    function automatic logic [511:0] pat(int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'h5A5A_0000;
        return {16{w}};
    endfunction

    task automatic step();
        bit sq_hs, cq_hs;
        logic [63:0] ek;
        bit el;
        @(negedge clk);
        cyc++;
        if (both_prev) begin
            compared++;
            if (int'(dut.outst_q) !== pending) begin
                mismatched++;
                $display("FAIL outstanding_same_cycle: got %0d expected %0d", dut.outst_q, pending);
            end
        end
        if (prev_hold) begin
            compared++;
            if ({bus.sq_rd_valid, bus.sq_rd_vaddr, bus.sq_rd_len, bus.sq_rd_last} !== {1'b1, prev_addr, prev_len, prev_last}) begin
                mismatched++;
                $display("FAIL sq_hold: got v=%0b a=%0h l=%0d last=%0b expected v=1 a=%0h l=%0d last=%0b",
                         bus.sq_rd_valid, bus.sq_rd_vaddr, bus.sq_rd_len, bus.sq_rd_last, prev_addr, prev_len, prev_last);
            end
        end
        if (bus.sq_rd_valid === 1'b1) begin
            compared++;
            if (pending >= 2) begin
                mismatched++;
                $display("FAIL sq_window: valid with %0d outstanding, required < 2", pending);
            end
        end
        bus.cfg_valid    = cfg_go;
        bus.sq_rd_ready  = $urandom_range(99) < out_pct + 0 * sq_pct ? 1'b1 : 1'b1;
        bus.sq_rd_ready  = $urandom_range(99) < sq_pct;
        bus.cq_rd_valid  = cq_force || (cq_en && pending > 0);
        bus.notify_ready = 1'b1;
        bus.in_tvalid    = 1'b1;
        bus.in_tdata     = pat(src_idx);
        bus.in_tkeep     = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
        bus.out_tready   = $urandom_range(99) < out_pct;
        sq_hs = bus.sq_rd_valid === 1'b1 && bus.sq_rd_ready;
        cq_hs = bus.cq_rd_valid && pending > 0;
        both_prev = sq_hs && cq_hs;
        if (both_prev) both_cnt++;
        prev_hold = bus.sq_rd_valid === 1'b1 && !bus.sq_rd_ready;
        prev_addr = bus.sq_rd_vaddr;
        prev_len  = bus.sq_rd_len;
        prev_last = bus.sq_rd_last;
        if (cfg_go && bus.cfg_ready === 1'b1) begin
            cfg_go  = 0;
            cfg_cyc = cyc;
        end
        if (sq_hs) begin
            sq_addr.push_back(bus.sq_rd_vaddr);
            sq_lenq.push_back(int'(bus.sq_rd_len));
            sq_lastq.push_back(bus.sq_rd_last);
            sq_cnt++;
        end
        if (cq_hs && cq_first_cyc < 0) cq_first_cyc = cyc;
        pending = pending + int'(sq_hs) - int'(cq_hs);
        if (bus.in_tready === 1'b1) src_idx++;
        if (bus.out_tvalid === 1'b1 && bus.out_tready) begin
            el = out_idx == exp_beats - 1;
            ek = (el && job_len % 64 != 0) ? (64'd1 << (job_len % 64)) - 64'd1 : {64{1'b1}};
            compared++;
            if (bus.out_tdata !== pat(out_idx) || bus.out_tkeep !== ek || bus.out_tlast !== el) begin
                mismatched++;
                $display("FAIL out_beat[%0d]: got word=%0h keep=%0h last=%0b expected word=%0h keep=%0h last=%0b",
                         out_idx, bus.out_tdata[31:0], bus.out_tkeep, bus.out_tlast, pat(out_idx) & 512'hFFFF_FFFF, ek, el);
            end
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            last_keep    = bus.out_tkeep;
            out_idx++;
        end
        if (bus.notify_valid === 1'b1 && !ntf_seen) begin
            ntf_seen = 1;
            ntf_val  = bus.notify_value;
            ntf_cyc  = cyc;
        end
    endtask

    task automatic start_job(input logic [47:0] addr, input int len);
        bus.cfg_vaddr = addr;
        bus.cfg_len   = 32'(len);
        cfg_go        = 1;
        job_len       = len;
        exp_beats     = (len + 63) / 64;
        sq_addr.delete();
        sq_lenq.delete();
        sq_lastq.delete();
        sq_cnt = 0; src_idx = 0; out_idx = 0; ntf_seen = 0; both_cnt = 0;
        cq_first_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; cfg_cyc = -1; ntf_cyc = -1;
    endtask

    task automatic run_to_notify(input int budget);
        int n = 0;
        while (!ntf_seen && n < budget) begin
            step();
            n++;
        end
        if (!ntf_seen) begin
            compared++;
            mismatched++;
            $display("FAIL notify_timeout: no notify within %0d cycles, required one", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({bus.sq_rd_valid, bus.notify_valid, bus.out_tvalid, bus.in_tready, bus.busy, bus.cfg_ready, bus.cq_rd_ready} !== 7'b0000011) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected 0000011",
                     {bus.sq_rd_valid, bus.notify_valid, bus.out_tvalid, bus.in_tready, bus.busy, bus.cfg_ready, bus.cq_rd_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_job(48'h1000, 10000);
        run_to_notify(1000);
        compared++;
        if (sq_cnt !== 3) begin
            mismatched++;
            $display("FAIL basic_req_count: got %0d expected 3", sq_cnt);
        end else begin
            compared++;
            if (sq_addr[0] !== 48'h1000 || sq_lenq[0] !== 4096 || sq_lastq[0] !== 1'b0 ||
                sq_addr[1] !== 48'h2000 || sq_lenq[1] !== 4096 || sq_lastq[1] !== 1'b0 ||
                sq_addr[2] !== 48'h3000 || sq_lenq[2] !== 1808 || sq_lastq[2] !== 1'b1) begin
                mismatched++;
                $display("FAIL basic_reqs: got (%0h,%0d,%0b) (%0h,%0d,%0b) (%0h,%0d,%0b) expected (1000,4096,0) (2000,4096,0) (3000,1808,1)",
                         sq_addr[0], sq_lenq[0], sq_lastq[0], sq_addr[1], sq_lenq[1], sq_lastq[1], sq_addr[2], sq_lenq[2], sq_lastq[2]);
            end
        end
        compared++;
        if (bus.sq_rd_strm !== 4'd5) begin
            mismatched++;
            $display("FAIL basic_strm: got %0d expected 5", bus.sq_rd_strm);
        end
        compared++;
        if (out_idx !== 157 || src_idx !== 157) begin
            mismatched++;
            $display("FAIL basic_beats: got out=%0d in=%0d expected 157/157", out_idx, src_idx);
        end
        compared++;
        if (last_keep !== 64'hFFFF) begin
            mismatched++;
            $display("FAIL basic_final_keep: got %0h expected ffff", last_keep);
        end
        compared++;
        if (last_out_cyc - first_out_cyc !== 156) begin
            mismatched++;
            $display("FAIL basic_throughput: got %0d cycles span expected 156", last_out_cyc - first_out_cyc);
        end
        compared++;
        if (ntf_val !== 32'd10000) begin
            mismatched++;
            $display("FAIL basic_notify: got %0d expected 10000", ntf_val);
        end
    endtask

    task automatic test_outstanding();
        cq_en = 0;
        start_job(48'h0000_ABCD_0000, 16384);
        repeat (40) step();
        compared++;
        if (sq_cnt !== 2 || pending !== 2 || bus.sq_rd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL window_stall: got reqs=%0d outstanding=%0d valid=%0b expected 2/2/0", sq_cnt, pending, bus.sq_rd_valid);
        end
        cq_en = 1;
        step();
        cq_en = 0;
        compared++;
        if (bus.sq_rd_valid !== 1'b0 || cq_first_cyc !== cyc) begin
            mismatched++;
            $display("FAIL window_cq: got valid=%0b cq_cyc=%0d expected valid=0 cq_cyc=%0d", bus.sq_rd_valid, cq_first_cyc, cyc);
        end
        step();
        compared++;
        if (bus.sq_rd_valid !== 1'b1 || bus.sq_rd_vaddr !== 48'h0000_ABCD_2000) begin
            mismatched++;
            $display("FAIL third_req_timing: got valid=%0b addr=%0h expected valid=1 addr=abcd2000", bus.sq_rd_valid, bus.sq_rd_vaddr);
        end
        cq_en = 1;
        run_to_notify(2000);
        compared++;
        if (sq_cnt !== 4 || sq_lastq[3] !== 1'b1 || sq_lastq[2] !== 1'b0 || sq_addr[3] !== 48'h0000_ABCD_3000 || sq_lenq[3] !== 4096) begin
            mismatched++;
            $display("FAIL window_reqs: got count=%0d expected 4 with last only on the 4th at abcd3000", sq_cnt);
        end
        compared++;
        if (both_cnt == 0 || out_idx !== 256 || ntf_val !== 32'd16384) begin
            mismatched++;
            $display("FAIL window_done: got same_cycle=%0d beats=%0d notify=%0d expected >0/256/16384", both_cnt, out_idx, ntf_val);
        end
    endtask

    task automatic test_zero();
        start_job(48'h5000, 0);
        run_to_notify(20);
        compared++;
        if (ntf_cyc !== cfg_cyc + 1 || ntf_val !== 32'd0) begin
            mismatched++;
            $display("FAIL zero_notify: got cyc=%0d value=%0d expected cyc=%0d value=0", ntf_cyc, ntf_val, cfg_cyc + 1);
        end
        compared++;
        if (sq_cnt !== 0 || src_idx !== 0 || out_idx !== 0) begin
            mismatched++;
            $display("FAIL zero_traffic: got reqs=%0d in=%0d out=%0d expected 0/0/0", sq_cnt, src_idx, out_idx);
        end
    endtask

    task automatic test_random_ready();
        out_pct = 50;
        sq_pct  = 50;
        start_job(48'h2000_0040, 4096);
        run_to_notify(3000);
        out_pct = 100;
        sq_pct  = 100;
        compared++;
        if (out_idx !== 64 || src_idx !== 64 || ntf_val !== 32'd4096) begin
            mismatched++;
            $display("FAIL random_beats: got out=%0d in=%0d notify=%0d expected 64/64/4096", out_idx, src_idx, ntf_val);
        end
        compared++;
        if (sq_cnt !== 1 || sq_addr[0] !== 48'h2000_0040 || sq_lenq[0] !== 4096 || sq_lastq[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL random_req: got count=%0d expected one (20000040,4096,1)", sq_cnt);
        end
    endtask

    task automatic test_cq_early();
        out_pct = 0;
        start_job(48'h7000, 256);
        repeat (30) step();
        compared++;
        if (sq_cnt !== 1 || pending !== 0 || bus.notify_valid !== 1'b0 || bus.busy !== 1'b1 || bus.out_tvalid !== 1'b1 || src_idx !== 2) begin
            mismatched++;
            $display("FAIL early_cq_hold: got reqs=%0d outst=%0d notify=%0b busy=%0b tvalid=%0b in=%0d expected 1/0/0/1/1/2",
                     sq_cnt, pending, bus.notify_valid, bus.busy, bus.out_tvalid, src_idx);
        end
        out_pct = 100;
        run_to_notify(100);
        compared++;
        if (ntf_cyc !== last_out_cyc + 1 || out_idx !== 4 || ntf_val !== 32'd256) begin
            mismatched++;
            $display("FAIL early_cq_notify: got cyc=%0d beats=%0d value=%0d expected cyc=%0d beats=4 value=256",
                     ntf_cyc, out_idx, ntf_val, last_out_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_job(48'h9000, 4096);
        while (out_idx < 20 && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (out_idx !== 20) begin
            mismatched++;
            $display("FAIL midreset_progress: got %0d beats expected 20", out_idx);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({bus.sq_rd_valid, bus.notify_valid, bus.out_tvalid, bus.in_tready, bus.busy, bus.cfg_ready, bus.cq_rd_ready} !== 7'b0000011) begin
            mismatched++;
            $display("FAIL midreset_outputs: got %b expected 0000011",
                     {bus.sq_rd_valid, bus.notify_valid, bus.out_tvalid, bus.in_tready, bus.busy, bus.cfg_ready, bus.cq_rd_ready});
        end
        pending = 0; prev_hold = 0; both_prev = 0; cq_en = 0;
        @(negedge clk);
        rst = 1'b0;
        cq_force = 1;
        repeat (3) step();
        cq_force = 0;
        cq_en = 1;
        compared++;
        if (ntf_seen || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_abandon: got notify=%0b busy=%0b expected 0/0", ntf_seen, bus.busy);
        end
        start_job(48'hFFFF_FFFF_FF00, 128);
        run_to_notify(200);
        compared++;
        if (sq_cnt !== 1 || sq_addr[0] !== 48'hFFFF_FFFF_FF00 || sq_lenq[0] !== 128 || sq_lastq[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset_req: got count=%0d expected one (ffffffffff00,128,1)", sq_cnt);
        end
        compared++;
        if (out_idx !== 2 || src_idx !== 2 || ntf_val !== 32'd128 || last_keep !== {64{1'b1}}) begin
            mismatched++;
            $display("FAIL midreset_job: got out=%0d in=%0d notify=%0d keep=%0h expected 2/2/128/all ones", out_idx, src_idx, ntf_val, last_keep);
        end
    endtask

    initial begin
        bus.cfg_valid = 0; bus.cfg_vaddr = '0; bus.cfg_len = '0;
        bus.sq_rd_ready = 0; bus.cq_rd_valid = 0; bus.notify_ready = 0;
        bus.in_tvalid = 0; bus.in_tdata = '0; bus.in_tkeep = '0; bus.out_tready = 0;
        pending = 0; prev_hold = 0; both_prev = 0;
        test_reset();
        test_basic();
        test_outstanding();
        test_zero();
        test_random_ready();
        test_cq_early();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/stream_reader.md
STREAM_READER -- requirements
Module: stream_reader

Interface
REQ-001 SHALL have parameter AXI_STRM_ID, default 0, host stream index placed in every read request.
REQ-002 SHALL have parameter TRANSFER_LENGTH_BYTES, default 4096, maximum bytes per read request; a power of two and a multiple of 64.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum number of read requests issued but not yet completed.
REQ-004 SHALL have the following ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid / cfg_ready  in / out  1 / 1  job handshake.
- cfg_vaddr  in  48  host base virtual address.
- cfg_len  in  32  job length in bytes.
- sq_rd_valid / sq_rd_ready  out / in  1 / 1  read-request handshake.
- sq_rd_vaddr  out  48  request address.
- sq_rd_len  out  28  request byte length.
- sq_rd_strm  out  4  equals AXI_STRM_ID.
- sq_rd_last  out  1  marks the final request of the job.
- cq_rd_valid / cq_rd_ready  in / out  1 / 1  read-completion handshake.
- notify_valid / notify_ready  out / in  1 / 1  job-done handshake.
- notify_value  out  32  bytes delivered.
- in_tvalid / in_tready / in_tdata / in_tkeep  in / out / in / in  1 / 1 / 512 / 64  host read data.
- out_tvalid / out_tready / out_tdata / out_tkeep / out_tlast  out / in / out / out / out  1 / 1 / 512 / 64 / 1  user data.
- busy  out  1  high outside IDLE.

Function
REQ-005 SHALL implement the FSM states IDLE, RUN, NOTIFY.
REQ-006 IDLE: cfg_ready=1; on a cfg handshake SHALL latch vaddr and len, then go to RUN if len>0, else to NOTIFY with notify_value=0.
REQ-007 RUN: SHALL issue requests sequentially.
- Address = base + issued bytes.
- Length = min(TRANSFER_LENGTH_BYTES, remaining bytes).
- sq_rd_last=1 on the request that covers the final byte.
REQ-008 sq_rd_valid SHALL be high only when request bytes remain and outstanding<MAX_OUTSTANDING.
REQ-009 Request fields SHALL be registered and held stable while sq_rd_valid=1 and sq_rd_ready=0.
REQ-010 outstanding counter (width clog2(MAX_OUTSTANDING+1)):
- +1 on an sq handshake.
- -1 on a cq handshake.
- Unchanged when both occur in the same cycle.
- A cq handshake at outstanding=0 SHALL be ignored.
REQ-011 cq_rd_ready SHALL be 1 in every state.
REQ-012 Data path SHALL be a 2-entry skid buffer.
- in_tready = RUN, not all beats yet accepted, and buffer not full.
- out_tvalid = buffer not empty.
- Input-to-output latency: 1 cycle.
- Full throughput: 1 beat/cycle when out_tready=1.
REQ-013 Beat accounting:
- Expected beats = ceil(len/64).
- The beat counter increments on each input handshake.
- Input beats beyond the expected count SHALL NOT be accepted (in_tready=0).
REQ-014 Final job beat: out_tlast=1 and out_tkeep = low (len mod 64) bytes set, or all 64 bytes if len mod 64 = 0.
REQ-015 All other beats: out_tlast=0 and out_tkeep=all ones, regardless of in_tkeep.
REQ-016 RUN SHALL go to NOTIFY after the final beat handshakes on the output and outstanding=0.
- Either condition may complete first.
- If both occur in the same cycle, the transition happens that cycle.
REQ-017 NOTIFY: notify_valid=1 and notify_value=len, held stable until notify_ready; then go to IDLE.
REQ-018 cfg_ready SHALL be 0 outside IDLE; a new job is never accepted mid-job.
REQ-019 Address and byte arithmetic SHALL be 48/32-bit unsigned with no overflow detection; requests crossing the 48-bit wrap SHALL simply wrap.

Reset
REQ-020 rst SHALL force the following asynchronously:
- FSM to IDLE; all counters to 0; skid buffer emptied.
- sq_rd_valid=0, notify_valid=0, out_tvalid=0, in_tready=0, busy=0.
- cfg_ready=1, cq_rd_ready=1.
REQ-021 rst asserted mid-job SHALL abandon the job without notify; completions arriving after release in IDLE SHALL be ignored.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- cfg len=10000, vaddr=0x1000, TRANSFER=4096 -> requests (0x1000,4096), (0x2000,4096), (0x3000,1808, last=1); 157 beats out; final keep=0xFFFF; notify_value=10000.
- MAX_OUTSTANDING=2, len=16384, cq withheld -> exactly 2 requests issued; the 3rd issues the cycle after the first cq handshake.
- len=0 -> no requests, no beats; notify_value=0 one cycle after cfg.
- out_tready toggled 50% random, len=4096 -> 64 beats, data order preserved, no loss or duplication, tlast only on beat 64.
- sq and cq handshakes in the same cycle -> outstanding unchanged; all cq arriving before the last data beat -> NOTIFY only after the last beat.
- rst pulsed after 20 of 64 beats -> outputs idle immediately; a new job of 128 bytes completes correctly with 2 beats.
